// File: rtl/gf2_pkg.sv
// rtl/gf2_pkg.sv - shared types and field constants for the GF(2)[x] multiplier
package gf2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LO    = 3'd1,
        ST_HI    = 3'd2,
        ST_MID   = 3'd3,
        ST_FOLD1 = 3'd4,
        ST_FOLD2 = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // GF(2^131): x^131 + x^13 + x^2 + x + 1
    localparam int             GF131_W        = 131;
    localparam logic [130:0]   GF131_POLY_LOW = 131'h2007;

    // GF(2^163): x^163 + x^7 + x^6 + x^3 + 1
    localparam int             GF163_W        = 163;
    localparam logic [162:0]   GF163_POLY_LOW = 163'hC9;

    // carry-less product of two n-bit operands has degree 2n-2
    function automatic int clmul_width(input int in_w);
        return 2 * in_w - 1;
    endfunction

endpackage

// File: rtl/gf2_clmul_comb.sv
// rtl/gf2_clmul_comb.sv - H x H combinational schoolbook carry-less multiplier
module gf2_clmul_comb
    import gf2_pkg::*;
#(
    parameter int H = 66
) (
    input  logic [H-1:0]              a,
    input  logic [H-1:0]              b,
    output logic [clmul_width(H)-1:0] p
);

    localparam int PW = clmul_width(H);

    // XOR-accumulate one shifted copy of a per set bit of b
    always_comb begin
        p = '0;
        for (int i = 0; i < H; i++) begin
            if (b[i]) begin
                p = p ^ (PW'(a) << i);
            end
        end
    end

endmodule

// File: rtl/gf2_karatsuba_seq_mult.sv
// rtl/gf2_karatsuba_seq_mult.sv - three-cycle Karatsuba GF(2)[x] multiplier with optional reduction
module gf2_karatsuba_seq_mult
    import gf2_pkg::*;
#(
    parameter int             W        = GF131_W,
    parameter int             H        = (W + 1) / 2,
    parameter logic [W-1:0]   POLY_LOW = W'(GF131_POLY_LOW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-2:0]   y,
    output logic             busy
);

    localparam int PW = clmul_width(H);
    localparam int RW = 2 * W - 1;
    localparam int DW = 2 * H;

    state_t state, state_nx;

    logic [W-1:0]  a_q, b_q;
    logic          mode_q;
    logic [PW-1:0] z0_q, z2_q;
    logic [RW-1:0] p_q, y_q;

    logic [DW-1:0] a_pad, b_pad;
    logic [H-1:0]  a_lo, a_hi, b_lo, b_hi;
    logic [H-1:0]  mul_a, mul_b;
    logic [PW-1:0] mul_p;
    logic [PW-1:0] z1;
    logic [RW-1:0] p_mid;

    // odd W leaves the upper half one bit short; zero-extend so both halves are H wide
    assign a_pad = DW'(a_q);
    assign b_pad = DW'(b_q);
    assign a_lo  = a_pad[H-1:0];
    assign a_hi  = a_pad[DW-1:H];
    assign b_lo  = b_pad[H-1:0];
    assign b_hi  = b_pad[DW-1:H];

    // one fold: x^W == POLY_LOW, so the upper part is multiplied by POLY_LOW and folded down
    function automatic logic [RW-1:0] fold(input logic [RW-1:0] v);
        logic [RW-1:0] r;
        r = RW'(v[W-1:0]);
        for (int i = 0; i < W - 1; i++) begin
            if (v[W+i]) begin
                r = r ^ (RW'(POLY_LOW) << i);
            end
        end
        return r;
    endfunction

    gf2_clmul_comb #(.H(H)) u_clmul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // steer the single sub-multiplier to the partial product of the current step
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_LO:   begin mul_a = a_lo;        mul_b = b_lo;        end
            ST_HI:   begin mul_a = a_hi;        mul_b = b_hi;        end
            ST_MID:  begin mul_a = a_lo ^ a_hi; mul_b = b_lo ^ b_hi; end
            default: ;
        endcase
    end

    // recombine: middle term is zm ^ z0 ^ z2; bits past 2W-2 are always zero and drop off
    always_comb begin
        z1    = mul_p ^ z0_q ^ z2_q;
        p_mid = RW'(z0_q) ^ (RW'(z1) << H) ^ (RW'(z2_q) << (2 * H));
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = ST_LO;
            end
            ST_LO:    state_nx = ST_HI;
            ST_HI:    state_nx = ST_MID;
            ST_MID:   state_nx = mode_q ? ST_FOLD1 : ST_DONE;
            ST_FOLD1: state_nx = ST_FOLD2;
            ST_FOLD2: state_nx = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    // operand capture, partial products, folds; y only changes on the way into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            z0_q   <= '0;
            z2_q   <= '0;
            p_q    <= '0;
            y_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= mode;
                    end
                end
                ST_LO:  z0_q <= mul_p;
                ST_HI:  z2_q <= mul_p;
                ST_MID: begin
                    if (mode_q) begin
                        p_q <= p_mid;
                    end else begin
                        y_q <= p_mid;
                    end
                end
                ST_FOLD1: p_q <= fold(p_q);
                ST_FOLD2: y_q <= fold(p_q);
                default:  ;
            endcase
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_gf2_karatsuba_seq_mult.sv
// tb/tb_gf2_karatsuba_seq_mult.sv - randomized self-checking bench for gf2_karatsuba_seq_mult
module tb_gf2_karatsuba_seq_mult;

    localparam int           W    = 131;
    localparam int           YW   = 2 * W - 1;
    localparam logic [130:0] POLY = 131'h2007;
    localparam logic [130:0] POLY4 = 131'h3;

    logic            clk = 1'b0;
    logic            rst_n;

    logic            in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic [W-1:0]    a, b;
    logic [YW-1:0]   y;

    logic            in_valid4, in_ready4, mode4, out_valid4, out_ready4, busy4;
    logic [3:0]      a4, b4;
    logic [6:0]      y4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gf2_karatsuba_seq_mult #(.W(W), .POLY_LOW(POLY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy)
    );

    gf2_karatsuba_seq_mult #(.W(4), .POLY_LOW(4'h3)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .mode(mode4), .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .y(y4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference: shift-and-xor product, then long division by x^w + poly from the top bit down
    function automatic logic [YW-1:0] ref_mul(input logic [W-1:0] av, input logic [W-1:0] bv,
                                              input logic m, input int w, input logic [130:0] poly);
        logic [YW-1:0] p;
        logic [YW-1:0] modp;
        p = '0;
        for (int i = 0; i < w; i++)
            if (bv[i]) p = p ^ (YW'(av) << i);
        if (m) begin
            modp    = YW'(poly);
            modp[w] = 1'b1;
            for (int d = 2 * w - 2; d >= w; d--)
                if (p[d]) p = p ^ (modp << (d - w));
        end
        return p;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // present one operand pair, wait for out_valid, check latency/in_ready/result
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m);
        int  lat;
        logic ready_seen;
        @(negedge clk);
        a = av; b = bv; mode = m; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = rand_w(); b = rand_w(); mode = 1'($urandom);
        lat = 1;
        ready_seen = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("in_ready_while_busy", YW'(ready_seen), YW'(0));
        check("latency", YW'(lat), YW'(m ? 6 : 4));
        check("y", y, ref_mul(av, bv, m, W, POLY));
    endtask

    // hold the result for a few cycles, then complete the output handshake
    task automatic finish_op(input int hold);
        for (int k = 0; k < hold; k++) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic m);
        int n;
        @(negedge clk);
        a4 = av; b4 = bv; mode4 = m; in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w4_y", YW'(y4), ref_mul(W'(av), W'(bv), m, 4, POLY4));
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        logic [W-1:0]  x130, ta, tb;
        logic [YW-1:0] y_hold;
        logic          stable_ok;
        int            lat;

        rst_n = 1'b0;
        in_valid = 1'b0; mode = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        in_valid4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", YW'(in_ready), YW'(1));
        check("rst_out_valid", YW'(out_valid), YW'(0));
        check("rst_busy", YW'(busy), YW'(0));
        check("rst_y", y, '0);
        rst_n = 1'b1;

        // directed cases
        start_op(W'(1), W'(1), 1'b0);
        check("one_times_one", y, YW'(1));
        finish_op(0);

        x130 = '0;
        x130[130] = 1'b1;
        start_op(x130, x130, 1'b0);
        check("x130_sq", y, YW'(1) << 260);
        finish_op(1);

        start_op(x130, W'(2), 1'b1);
        check("x131_mod", y, YW'(131'h2007));
        finish_op(0);

        start_op('1, '1, 1'b1);
        finish_op(0);
        start_op('0, rand_w(), 1'b0);
        finish_op(0);

        // small instance
        op4(4'b1011, 4'b0111, 1'b0);
        check("w4_1011x0111", YW'(y4), YW'(7'h31));
        op4(4'hF, 4'hF, 1'b0);
        check("w4_FxF", YW'(y4), YW'(7'h55));
        for (int i = 0; i < 256; i++)
            op4(i[3:0], i[7:4], 1'b0);
        for (int i = 0; i < 256; i++)
            op4(i[3:0], i[7:4], 1'b1);

        // back-pressure: result held, new request waits for handshake
        start_op(rand_w(), rand_w(), 1'b0);
        y_hold = y;
        ta = rand_w(); tb = rand_w();
        a = ta; b = tb; mode = 1'b1; in_valid = 1'b1;
        stable_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (y !== y_hold || !out_valid || in_ready) stable_ok = 1'b0;
        end
        check("bp_stable", YW'(stable_ok), YW'(1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_after_handshake", YW'(in_ready), YW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_second_latency", YW'(lat), YW'(6));
        check("bp_second_y", y, ref_mul(ta, tb, 1'b1, W, POLY));
        finish_op(0);

        // asynchronous reset while in MID
        @(negedge clk);
        a = rand_w(); b = rand_w(); mode = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", YW'(busy), YW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", YW'(out_valid), YW'(0));
        check("rst_mid_in_ready", YW'(in_ready), YW'(1));
        check("rst_mid_y", y, '0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(rand_w(), rand_w(), 1'b1);
        finish_op(0);

        // random regression with zero / all-ones corners
        for (int it = 0; it < 2000; it++) begin
            case ($urandom_range(0, 7))
                0:       ta = '0;
                1:       ta = '1;
                default: ta = rand_w();
            endcase
            case ($urandom_range(0, 7))
                0:       tb = '0;
                1:       tb = '1;
                default: tb = rand_w();
            endcase
            start_op(ta, tb, 1'($urandom));
            finish_op(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
